// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter granting NREQ requesters exclusive write tenure over one shared WIDTH-bit q/qbar register.
// Optional feature macro HOLD_TIMEOUT_EN bounds each tenure to HOLD_MAX cycles and pulses timeout on forced release.
module dff_reg_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       wr_en,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qbar,
  output logic                  busy,
  output logic                  timeout
);
  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  generate
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
      $error("dff_reg_arbiter: NREQ must be in 2..8");
    end
    if (HOLD_MAX < 1) begin : g_bad_hold
      $error("dff_reg_arbiter: HOLD_MAX must be at least 1");
    end
  endgenerate

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    owner, owner_nxt, owner_inc;
  logic [IDX_W-1:0]    rr_ptr, rr_ptr_nxt;
  logic [NREQ-1:0]     gnt_nxt;
  logic [NREQ-1:0]     cand;
  logic [2*NREQ-1:0]   cand_dbl;
  logic [NREQ-1:0]     cand_rot;
  logic                pick_vld;
  logic [IDX_W-1:0]    pick_idx;
  logic [IDX_W:0]      pick_sum;
  logic [WIDTH-1:0]    owner_data;
  logic                owner_req, owner_wr;
  logic                do_write;
  logic                force_rel;

  // Rotate candidates so bit 0 is rr_ptr; the lowest set bit is the winner.
  assign cand_dbl = {cand, cand};
  assign cand_rot = NREQ'(cand_dbl >> rr_ptr);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    pick_vld = 1'b0;
    pick_idx = '0;
    pick_sum = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (cand_rot[off]) begin
        pick_vld = 1'b1;
        pick_sum = {1'b0, rr_ptr} + (IDX_W+1)'(off);
        pick_idx = (pick_sum >= (IDX_W+1)'(NREQ)) ? IDX_W'(pick_sum - (IDX_W+1)'(NREQ))
                                                   : IDX_W'(pick_sum);
      end
    end
  end

  always_comb begin
    owner_data = '0;
    owner_req  = 1'b0;
    owner_wr   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IDX_W'(i)) begin
        owner_data = wr_data[i*WIDTH +: WIDTH];
        owner_req  = req[i];
        owner_wr   = wr_en[i];
      end
    end
  end

  assign owner_inc = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;

`ifdef HOLD_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);

  logic [CNT_W-1:0] hold_cnt;
  logic [NREQ-1:0]  locked;
  logic [NREQ-1:0]  lock_set;

  assign force_rel = owner_req && (hold_cnt == CNT_W'(HOLD_MAX - 1));
  // A timed-out owner stays masked until it drops req, so it cannot win straight back.
  assign lock_set  = ((state == GRANT) && force_rel) ? (NREQ'(1) << owner) : '0;
  assign cand      = req & ~locked;

  always_ff @(posedge clock) begin
    if (clear) begin
      hold_cnt <= '0;
      locked   <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= (state == GRANT) ? hold_cnt + 1'b1 : '0;
      locked   <= (locked & req) | lock_set;
      timeout  <= (state == GRANT) && force_rel;
    end
  end
`else
  assign force_rel = 1'b0;
  assign cand      = req;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    do_write   = 1'b0;
    unique case (state)
      IDLE, RELEASE: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
        if (pick_vld) begin
          state_nxt = GRANT;
          gnt_nxt   = NREQ'(1) << pick_idx;
          owner_nxt = pick_idx;
        end
      end
      GRANT: begin
        // The owner's write lands even on the edge where its tenure ends.
        do_write = owner_wr;
        if (!owner_req || force_rel) begin
          gnt_nxt    = '0;
          rr_ptr_nxt = owner_inc;
          state_nxt  = RELEASE;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: clear is synchronous, so it is tested inside the clocked block and overrides everything at that edge.
  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= IDLE;
      gnt    <= '0;
      owner  <= '0;
      rr_ptr <= '0;
      q      <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values, independent of statement order.
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
      if (do_write) q <= owner_data;
    end
  end

  assign qbar = ~q;
  assign busy = (state == GRANT);

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Self-checking bench for dff_reg_arbiter (NREQ=4, WIDTH=8); expected grants and q values flow through scoreboard queues.
// The timeout scenario is exercised when HOLD_TIMEOUT_EN is defined, otherwise unbounded tenure is checked.
module tb_dff_reg_arbiter;
  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int HOLD_MAX = 15;

  logic                  clock = 1'b0;
  logic                  clear;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       wr_en;
  logic [NREQ*WIDTH-1:0] wr_data;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qbar;
  logic                  busy;
  logic                  timeout;

  int n_pass  = 0;
  int n_total = 0;

  logic [NREQ-1:0]  exp_gnt_q[$];
  logic [WIDTH-1:0] exp_q_q[$];

  always #5 clock = ~clock;

  dff_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
    .clock   (clock),
    .clear   (clear),
    .req     (req),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .gnt     (gnt),
    .q       (q),
    .qbar    (qbar),
    .busy    (busy),
    .timeout (timeout)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_slice(input int i, input logic [WIDTH-1:0] v);
    wr_data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic apply_clear();
    clear = 1'b1;
    req   = '0;
    wr_en = '0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear   = 1'b1;
    req     = 4'hF;
    wr_en   = 4'hF;
    wr_data = {8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    tick();
    n_total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want %b", gnt, 4'b0000); else n_pass++;
    n_total++; if (q !== 8'h00) $display("FAIL reset_q: got %h want %h", q, 8'h00); else n_pass++;
    n_total++; if (qbar !== 8'hFF) $display("FAIL reset_qbar: got %h want %h", qbar, 8'hFF); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else n_pass++;
    clear = 1'b0;
    req   = '0;
    wr_en = '0;
    tick();
    n_total++; if (gnt !== 4'b0000) $display("FAIL idle_gnt: got %b want %b", gnt, 4'b0000); else n_pass++;
  endtask

  task automatic test_single_write();
    logic [WIDTH-1:0] e;
    req   = 4'b0100;
    wr_en = 4'b0001;
    set_slice(0, 8'h11);
    tick();
    n_total++; if (gnt !== 4'b0100) $display("FAIL single_gnt: got %b want %b", gnt, 4'b0100); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
    n_total++; if (q !== 8'h00) $display("FAIL single_idle_write: got %h want %h", q, 8'h00); else n_pass++;
    wr_en = 4'b0101;
    set_slice(2, 8'hA5);
    exp_q_q.push_back(8'hA5);
    tick();
    e = exp_q_q.pop_front();
    n_total++; if (q !== e) $display("FAIL single_q: got %h want %h", q, e); else n_pass++;
    n_total++; if (qbar !== ~e) $display("FAIL single_qbar: got %h want %h", qbar, ~e); else n_pass++;
    wr_en = 4'b0001;
    set_slice(0, 8'h77);
    exp_q_q.push_back(8'hA5);
    tick();
    e = exp_q_q.pop_front();
    n_total++; if (q !== e) $display("FAIL nonowner_write: got %h want %h", q, e); else n_pass++;
    n_total++; if (gnt !== 4'b0100) $display("FAIL single_hold_gnt: got %b want %b", gnt, 4'b0100); else n_pass++;
    req   = '0;
    wr_en = '0;
    tick();
    n_total++; if (gnt !== 4'b0000) $display("FAIL single_release_gnt: got %b want %b", gnt, 4'b0000); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL single_release_busy: got %b want 0", busy); else n_pass++;
    tick();
  endtask

  task automatic test_round_robin();
    int gap;
    int cyc;
    int k;
    bit phase;
    logic [NREQ-1:0]  eg;
    logic [WIDTH-1:0] e;
    apply_clear();
    for (int i = 0; i < 5; i++) exp_gnt_q.push_back(4'(1) << (i % NREQ));
    req   = 4'hF;
    wr_en = '0;
    gap   = -1;
    cyc   = 0;
    k     = 0;
    phase = 1'b0;
    tick();
    while ((exp_gnt_q.size() != 0 || exp_q_q.size() != 0) && cyc < 60) begin
      n_total++;
      if (busy !== (gnt != '0) || !$onehot0(gnt))
        $display("FAIL rr_busy_onehot: gnt %b busy %b, want one-hot gnt matching busy", gnt, busy);
      else n_pass++;
      if (gnt == '0) begin
        if (gap >= 0) gap++;
        req   = 4'hF;
        wr_en = '0;
      end else if (!phase) begin
        eg = exp_gnt_q.pop_front();
        n_total++; if (gnt !== eg) $display("FAIL rr_grant_order: got %b want %b", gnt, eg); else n_pass++;
        if (gap >= 0) begin
          n_total++; if (gap != 1) $display("FAIL rr_dead_cycles: got %0d want 1", gap); else n_pass++;
        end
        gap = 0;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) k = i;
        wr_en = NREQ'(1) << k;
        e     = WIDTH'(32'h30 + cyc);
        set_slice(k, e);
        exp_q_q.push_back(e);
        phase = 1'b1;
      end else begin
        e = exp_q_q.pop_front();
        n_total++; if (q !== e) $display("FAIL rr_q: got %h want %h", q, e); else n_pass++;
        req[k] = 1'b0;
        wr_en  = '0;
        phase  = 1'b0;
      end
      cyc++;
      tick();
    end
    if (exp_gnt_q.size() != 0 || exp_q_q.size() != 0) begin
      n_total++;
      $display("FAIL rr_budget: %0d grants and %0d writes still pending, want 0", exp_gnt_q.size(), exp_q_q.size());
      exp_gnt_q.delete();
      exp_q_q.delete();
    end
    req   = '0;
    wr_en = '0;
    tick();
    tick();
  endtask

  task automatic test_final_write();
    logic [WIDTH-1:0] e;
    apply_clear();
    req = 4'b0110;
    tick();
    n_total++; if (gnt !== 4'b0010) $display("FAIL final_gnt: got %b want %b", gnt, 4'b0010); else n_pass++;
    req   = 4'b0100;
    wr_en = 4'b0010;
    set_slice(1, 8'h3C);
    exp_q_q.push_back(8'h3C);
    tick();
    e = exp_q_q.pop_front();
    n_total++; if (q !== e) $display("FAIL final_q: got %h want %h", q, e); else n_pass++;
    n_total++; if (gnt !== 4'b0000) $display("FAIL final_release_gnt: got %b want %b", gnt, 4'b0000); else n_pass++;
    wr_en = '0;
    tick();
    n_total++; if (gnt !== 4'b0100) $display("FAIL final_next_gnt: got %b want %b", gnt, 4'b0100); else n_pass++;
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_withdraw();
    req = 4'b0010;
    tick();
    n_total++; if (gnt !== 4'b0010) $display("FAIL withdraw_gnt: got %b want %b", gnt, 4'b0010); else n_pass++;
    req = 4'b0110;
    tick();
    req = 4'b0010;
    tick();
    n_total++; if (gnt !== 4'b0010) $display("FAIL withdraw_hold: got %b want %b", gnt, 4'b0010); else n_pass++;
    req = '0;
    tick();
    tick();
    n_total++; if (gnt !== 4'b0000) $display("FAIL withdraw_no_grant: got %b want %b", gnt, 4'b0000); else n_pass++;
    tick();
    n_total++; if (gnt !== 4'b0000) $display("FAIL withdraw_idle: got %b want %b", gnt, 4'b0000); else n_pass++;
    n_total++; if (q !== 8'h3C) $display("FAIL withdraw_q_hold: got %h want %h", q, 8'h3C); else n_pass++;
  endtask

  task automatic test_clear_mid();
    req = 4'b0001;
    tick();
    n_total++; if (gnt !== 4'b0001) $display("FAIL clrmid_gnt: got %b want %b", gnt, 4'b0001); else n_pass++;
    wr_en = 4'b0001;
    set_slice(0, 8'h99);
    clear = 1'b1;
    tick();
    n_total++; if (gnt !== 4'b0000) $display("FAIL clrmid_gnt_drop: got %b want %b", gnt, 4'b0000); else n_pass++;
    n_total++; if (q !== 8'h00) $display("FAIL clrmid_q: got %h want %h", q, 8'h00); else n_pass++;
    n_total++; if (qbar !== 8'hFF) $display("FAIL clrmid_qbar: got %h want %h", qbar, 8'hFF); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL clrmid_busy: got %b want 0", busy); else n_pass++;
    clear = 1'b0;
    wr_en = '0;
    req   = 4'b1010;
    tick();
    n_total++; if (gnt !== 4'b0010) $display("FAIL clrmid_rr_ptr: got %b want %b", gnt, 4'b0010); else n_pass++;
    req = '0;
    tick();
    tick();
  endtask

`ifdef HOLD_TIMEOUT_EN
  task automatic test_timeout();
    int hold;
    int pulses;
    int t_at;
    int regrant;
    logic [NREQ-1:0] gnt_after;
    apply_clear();
    hold      = 0;
    pulses    = 0;
    t_at      = -10;
    regrant   = 0;
    gnt_after = 'x;
    req       = 4'b1000;
    tick();
    for (int cyc = 1; cyc <= 24; cyc++) begin
      if (cyc <= 16 && gnt == 4'b1000) hold++;
      if (cyc >= 17 && cyc <= 22 && gnt[3]) regrant++;
      if (timeout) begin
        pulses++;
        t_at = cyc;
      end
      if (cyc == t_at + 1) gnt_after = gnt;
      if (cyc == 23) begin
        n_total++; if (gnt !== 4'b1000) $display("FAIL to_rerequest: got %b want %b", gnt, 4'b1000); else n_pass++;
      end
      req[0] = (cyc >= 2 && cyc < 18);
      req[3] = (cyc < 20 || cyc >= 22);
      tick();
    end
    n_total++; if (hold != HOLD_MAX) $display("FAIL to_tenure: got %0d cycles want %0d", hold, HOLD_MAX); else n_pass++;
    n_total++; if (pulses != 1) $display("FAIL to_pulses: got %0d want 1", pulses); else n_pass++;
    n_total++; if (t_at != HOLD_MAX + 1) $display("FAIL to_when: got cycle %0d want %0d", t_at, HOLD_MAX + 1); else n_pass++;
    n_total++; if (gnt_after !== 4'b0001) $display("FAIL to_next_owner: got %b want %b", gnt_after, 4'b0001); else n_pass++;
    n_total++; if (regrant != 0) $display("FAIL to_locked: got %0d regrant cycles want 0", regrant); else n_pass++;
    req = '0;
    tick();
    tick();
  endtask
`else
  task automatic test_long_tenure();
    int hold;
    int pulses;
    apply_clear();
    hold   = 0;
    pulses = 0;
    req    = 4'b1000;
    tick();
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (gnt == 4'b1000) hold++;
      if (timeout) pulses++;
      req[0] = (cyc >= 2);
      tick();
    end
    n_total++; if (hold != 20) $display("FAIL long_tenure: got %0d cycles want 20", hold); else n_pass++;
    n_total++; if (pulses != 0) $display("FAIL long_timeout: got %0d pulses want 0", pulses); else n_pass++;
    req = 4'b0001;
    tick();
    tick();
    n_total++; if (gnt !== 4'b0001) $display("FAIL long_handover: got %b want %b", gnt, 4'b0001); else n_pass++;
    req = '0;
    tick();
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear   = 1'b1;
    req     = '0;
    wr_en   = '0;
    wr_data = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_final_write();
    test_withdraw();
    test_clear_mid();
`ifdef HOLD_TIMEOUT_EN
    test_timeout();
`else
    test_long_tenure();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
